// File: rtl/full_adder_pkg.sv
// Shared constants for the full_adder slice.
// Defaults for operand width and carry-event counter width.
package full_adder_pkg;

  localparam int DEF_WIDTH = 1;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder cell.
// Building block of the ripple chain in full_adder.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder with registered copies of its outputs
// and a saturating count of carry-out events.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             CarryOut,
  output logic             Ovf,
  output logic [WIDTH-1:0] S_q,
  output logic             CarryOut_q,
  output logic             Ovf_q,
  output logic [CNT_W-1:0] carry_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH:0] c;

  assign c[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder_cell u_cell (
      .a  (A[i]),
      .b  (B[i]),
      .ci (c[i]),
      .s  (S[i]),
      .co (c[i+1])
    );
  end

  assign CarryOut = c[WIDTH];
  // Signed overflow: carry into the MSB disagrees with carry out.
  assign Ovf      = c[WIDTH-1] ^ c[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      S_q        <= '0;
      CarryOut_q <= 1'b0;
      Ovf_q      <= 1'b0;
      carry_cnt  <= '0;
    end else begin
      S_q        <= S;
      CarryOut_q <= CarryOut;
      Ovf_q      <= Ovf;
      if (CarryOut && (carry_cnt != CNT_MAX))
        carry_cnt <= carry_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: 1-bit, 8-bit
// and 8-bit/2-bit-counter instances against an arithmetic model.
module tb_full_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       a1 = 0, b1 = 0, c1 = 0;
  logic       s1, co1, ov1, s1q, co1q, ov1q;
  logic [15:0] cnt1;

  logic [7:0] a8 = 0, b8 = 0;
  logic       ci8 = 0;
  logic [7:0] s8, s8q;
  logic       co8, ov8, co8q, ov8q;
  logic [15:0] cnt8;

  logic [7:0] a2 = 0, b2 = 0;
  logic       ci2 = 0;
  logic [7:0] s2, s2q;
  logic       co2, ov2, co2q, ov2q;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  full_adder #(.WIDTH(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .A(a1), .B(b1), .Cin(c1),
    .S(s1), .CarryOut(co1), .Ovf(ov1),
    .S_q(s1q), .CarryOut_q(co1q), .Ovf_q(ov1q),
    .carry_cnt(cnt1)
  );

  full_adder #(.WIDTH(8), .CNT_W(16)) u8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .Cin(ci8),
    .S(s8), .CarryOut(co8), .Ovf(ov8),
    .S_q(s8q), .CarryOut_q(co8q), .Ovf_q(ov8q),
    .carry_cnt(cnt8)
  );

  full_adder #(.WIDTH(8), .CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .A(a2), .B(b2), .Cin(ci2),
    .S(s2), .CarryOut(co2), .Ovf(ov2),
    .S_q(s2q), .CarryOut_q(co2q), .Ovf_q(ov2q),
    .carry_cnt(cnt2)
  );

  // Reference: unsigned sum for S/carry, signed range test for overflow.
  function automatic void ref_add(
    input int w, input int a, input int b, input int c,
    output int s, output int co, output int ov);
    int sum, sa, sb, ss;
    sum = a + b + c;
    s   = sum % (1 << w);
    co  = sum >> w;
    sa  = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb  = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    ss  = sa + sb + c;
    ov  = (ss > (1 << (w - 1)) - 1 || ss < -(1 << (w - 1))) ? 1 : 0;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({s1q, co1q, ov1q} !== 3'b000 || cnt1 !== 16'd0) begin
      errors++;
      $display("FAIL reset_u1: got q=%b cnt=%0d exp 000/0",
               {s1q, co1q, ov1q}, cnt1);
    end
    checks++;
    if ({s8q, co8q, ov8q} !== 10'd0 || cnt8 !== 16'd0) begin
      errors++;
      $display("FAIL reset_u8: got s=%h c=%b o=%b cnt=%0d exp 0",
               s8q, co8q, ov8q, cnt8);
    end
    checks++;
    if ({s2q, co2q, ov2q} !== 10'd0 || cnt2 !== 2'd0) begin
      errors++;
      $display("FAIL reset_u2: got s=%h c=%b o=%b cnt=%0d exp 0",
               s2q, co2q, ov2q, cnt2);
    end
  endtask

  task automatic test_truth_table();
    int s, co, ov;
    for (int i = 0; i < 8; i++) begin
      {a1, b1, c1} = 3'(i);
      #1;
      ref_add(1, i >> 2, (i >> 1) & 1, i & 1, s, co, ov);
      checks++;
      if ({s1, co1, ov1} !== {1'(s), 1'(co), 1'(ov)}) begin
        errors++;
        $display("FAIL truth_%0d%0d%0d: got s=%b c=%b o=%b exp %0d %0d %0d",
                 a1, b1, c1, s1, co1, ov1, s, co, ov);
      end
    end
  endtask

  task automatic test_boundaries();
    a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0; #1;
    checks++;
    if (s8 !== 8'h00 || co8 !== 1'b1 || ov8 !== 1'b0) begin
      errors++;
      $display("FAIL bnd_ff01: got s=%h c=%b o=%b exp 00 1 0",
               s8, co8, ov8);
    end
    a8 = 8'h7F; b8 = 8'h01; ci8 = 1'b0; #1;
    checks++;
    if (s8 !== 8'h80 || co8 !== 1'b0 || ov8 !== 1'b1) begin
      errors++;
      $display("FAIL bnd_7f01: got s=%h c=%b o=%b exp 80 0 1",
               s8, co8, ov8);
    end
    a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1; #1;
    checks++;
    if (s8 !== 8'hFF || co8 !== 1'b1 || ov8 !== 1'b0) begin
      errors++;
      $display("FAIL bnd_ones: got s=%h c=%b o=%b exp ff 1 0",
               s8, co8, ov8);
    end
    a8 = 8'h80; b8 = 8'h80; ci8 = 1'b0; #1;
    checks++;
    if (s8 !== 8'h00 || co8 !== 1'b1 || ov8 !== 1'b1) begin
      errors++;
      $display("FAIL bnd_8080: got s=%h c=%b o=%b exp 00 1 1",
               s8, co8, ov8);
    end
  endtask

  task automatic test_latency();
    rst = 1'b0;
    @(negedge clk);
    a8 = 8'h00; b8 = 8'h00; ci8 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h03; ci8 = 1'b1;
    #1;
    checks++;
    if (s8 !== 8'h09 || s8q !== 8'h00) begin
      errors++;
      $display("FAIL latency_pre: got s=%h s_q=%h exp 09 00", s8, s8q);
    end
    @(posedge clk); #1;
    checks++;
    if (s8q !== 8'h09) begin
      errors++;
      $display("FAIL latency_post: got s_q=%h exp 09", s8q);
    end
  endtask

  task automatic test_random();
    int s, co, ov, ncnt, a, b, c;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ncnt = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      c = int'($urandom_range(0, 1));
      if (n % 17 == 0) begin a = 255; b = 255; c = 1; end
      a8 = 8'(a); b8 = 8'(b); ci8 = 1'(c);
      #1;
      ref_add(8, a, b, c, s, co, ov);
      checks++;
      if (s8 !== 8'(s) || co8 !== 1'(co) || ov8 !== 1'(ov)) begin
        errors++;
        $display("FAIL rand_comb: %h+%h+%0d got %h %b %b exp %h %0d %0d",
                 a8, b8, ci8, s8, co8, ov8, s, co, ov);
      end
      ncnt += co;
      @(posedge clk); #1;
      checks++;
      if (s8q !== 8'(s) || co8q !== 1'(co) || ov8q !== 1'(ov) ||
          cnt8 !== 16'(ncnt)) begin
        errors++;
        $display("FAIL rand_reg: got %h %b %b cnt=%0d exp %h %0d %0d %0d",
                 s8q, co8q, ov8q, cnt8, s, co, ov, ncnt);
      end
    end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    a2 = 8'hFF; b2 = 8'h01; ci2 = 1'b0;
    exp_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      exp_cnt = (exp_cnt + 1 > 3) ? 3 : exp_cnt + 1;
      checks++;
      if (cnt2 !== 2'(exp_cnt)) begin
        errors++;
        $display("FAIL sat_edge%0d: got cnt=%0d exp %0d", k, cnt2, exp_cnt);
      end
    end
  endtask

  task automatic test_reset_priority();
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    a2 = 8'hF0; b2 = 8'h20; ci2 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (cnt2 !== 2'd2) begin
      errors++;
      $display("FAIL rstpri_setup: got cnt=%0d exp 2", cnt2);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cnt2 !== 2'd0 || s2q !== 8'h00 || co2q !== 1'b0) begin
      errors++;
      $display("FAIL rstpri_regs: got cnt=%0d s_q=%h c_q=%b exp 0 00 0",
               cnt2, s2q, co2q);
    end
    a2 = 8'hC3; b2 = 8'h7D; ci2 = 1'b1; #1;
    checks++;
    if (s2 !== 8'h41 || co2 !== 1'b1) begin
      errors++;
      $display("FAIL rstpri_comb: got s=%h c=%b exp 41 1", s2, co2);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cnt2 !== 2'd1 || s2q !== 8'h41 || co2q !== 1'b1) begin
      errors++;
      $display("FAIL rstpri_first: got cnt=%0d s_q=%h c_q=%b exp 1 41 1",
               cnt2, s2q, co2q);
    end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_boundaries();
    test_latency();
    test_random();
    test_saturation();
    test_reset_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/full_adder.md
FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 Parameter WIDTH SHALL default to 1 and set the operand and sum width in bits (WIDTH >= 1).
REQ-003 Parameter CNT_W SHALL default to 16 and set the carry-event counter width (CNT_W >= 2).
REQ-004 Port clk SHALL be: clk, input, 1, rising-edge clock for all registered outputs.
REQ-005 Port rst SHALL be: rst, input, 1, synchronous active-high reset.
REQ-006 Port A SHALL be: A, input, WIDTH, addend.
REQ-007 Port B SHALL be: B, input, WIDTH, addend.
REQ-008 Port Cin SHALL be: Cin, input, 1, carry into bit 0.
REQ-009 Port S SHALL be: S, output, WIDTH, combinational sum.
REQ-010 Port CarryOut SHALL be: CarryOut, output, 1, combinational carry out of the MSB.
REQ-011 Port Ovf SHALL be: Ovf, output, 1, combinational two's-complement overflow.
REQ-012 Port S_q SHALL be: S_q, output, WIDTH, registered S.
REQ-013 Port CarryOut_q SHALL be: CarryOut_q, output, 1, registered CarryOut.
REQ-014 Port Ovf_q SHALL be: Ovf_q, output, 1, registered Ovf.
REQ-015 Port carry_cnt SHALL be: carry_cnt, output, CNT_W, saturating count of clock edges sampled with CarryOut=1.
REQ-016 The block SHALL have no other inputs, so that it is fully functional when only clk, rst, A, B and Cin are driven.

Function
REQ-017 {CarryOut, S} SHALL equal A + B + Cin as an unsigned (WIDTH+1)-bit sum, with S taking the sum mod 2^WIDTH.
REQ-018 S, CarryOut and Ovf SHALL be purely combinational, with zero-cycle latency and no dependence on clk or rst.
REQ-019 For WIDTH=1, the outputs SHALL satisfy S = A^B^Cin and CarryOut = (A&B)|(A&Cin)|(B&Cin).
REQ-020 Ovf SHALL equal the carry into the MSB XOR CarryOut; for WIDTH=1, Ovf SHALL equal Cin XOR CarryOut.
REQ-021 On every rising edge of clk without rst, S_q, CarryOut_q and Ovf_q SHALL capture the current S, CarryOut and Ovf, giving one-cycle latency.
REQ-022 On every rising edge of clk without rst where CarryOut=1, carry_cnt SHALL increment by 1.
REQ-023 carry_cnt SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-024 When all inputs are known (non-X), all outputs SHALL be X-free, including for all-ones operands with Cin=1.

Reset
REQ-025 When rst=1 at a rising edge of clk, S_q, Ovf_q, CarryOut_q and carry_cnt SHALL all be set to 0.
REQ-026 rst SHALL take priority over capture and counting, so a carry that coincides with reset is not counted.
REQ-027 rst SHALL have no effect on S, CarryOut or Ovf, and asserting rst mid-operation SHALL only clear the registered state.
REQ-028 After reset, the first edge with rst=0 SHALL capture and count normally.

Structure
REQ-029 A shared package full_adder_pkg SHALL hold the default WIDTH and CNT_W constants.
REQ-030 The 1-bit cell SHALL be a sub-module full_adder_cell (ports a, b, ci, s, co), instantiated WIDTH times as a ripple chain.
REQ-031 The registers and counter SHALL reside in the full_adder top level.

Verification
REQ-032 For WIDTH=1, the bench SHALL apply all 8 combinations of A, B, Cin at 1 ns steps and check exact outputs: 000 -> S=0, C=0; 001 -> S=1, C=0; 011 -> S=0, C=1; 101 -> S=0, C=1; 111 -> S=1, C=1.
REQ-033 For WIDTH=8, A=0xFF, B=0x01, Cin=0 SHALL give S=0x00, CarryOut=1, Ovf=0; A=0x7F, B=0x01, Cin=0 SHALL give S=0x80, CarryOut=0, Ovf=1.
REQ-034 For registered latency, applying A=0x05, B=0x03, Cin=1 before an edge SHALL give S_q=0x09 after that edge, with S_q unchanged before it.
REQ-035 With CNT_W=2 and CarryOut held at 1 for 5 edges, carry_cnt SHALL read 1, 2, 3, 3, 3.
REQ-036 Asserting rst on an edge with CarryOut=1 and carry_cnt=2 SHALL give carry_cnt=0, S_q=0 and CarryOut_q=0, while S and CarryOut still track the inputs.
